// File: rtl/bus_dmx_1_m_reg.sv
// bus_dmx_1_m_reg
// Registered 1-to-M bus demultiplexer. Each output channel owns a one-entry
// holding register, so a stalled sink only blocks words addressed to it (and
// broadcasts, which need every channel). Out-of-range unicasts are accepted,
// discarded and counted in a saturating error counter.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   addr     destination channel index (ignored while bcast is high)
//   bcast    write the word to all M channels at once
//   X        input data word
//   x_valid  input word valid
//   x_ready  block accepts the word this cycle (independent of x_valid)
//   Y        output data, channel k at [k*N +: N]; idle value when not valid
//   y_valid  per-channel output valid
//   y_ready  per-channel sink ready
//   err_cnt  saturating count of dropped out-of-range transfers
//
// Handshake: a transfer on any port happens at a rising edge where its valid
// and ready are both high. Valid never depends on ready. A channel is free
// when it is empty or is being drained this cycle, which lets a drain and a
// reload of the same channel happen in the same cycle (full throughput).

module bus_dmx_1_m_reg #(
   parameter int N      = 8,
   parameter int M      = 8,
   parameter int AW     = 3,
   parameter int IDLE_Z = 1,
   parameter int CW     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   addr,
   input  logic            bcast,
   input  logic [N-1:0]    X,
   input  logic            x_valid,
   output logic            x_ready,
   output logic [M*N-1:0]  Y,
   output logic [M-1:0]    y_valid,
   input  logic [M-1:0]    y_ready,
   output logic [CW-1:0]   err_cnt
);

   localparam int NCH = 1 << AW;
   localparam logic [AW:0] M_LIM = (AW+1)'(M);

   logic [N-1:0]   hold [M];
   logic [M-1:0]   free;
   logic [NCH-1:0] free_ext;
   logic           in_range;
   logic           accept;
   logic [M-1:0]   load;

   assign free     = ~y_valid | y_ready;
   assign in_range = ({1'b0, addr} < M_LIM);

   // Address slots beyond M-1 read as always free, so a dropped transfer
   // never stalls and no separate out-of-range mux term is needed.
   always_comb begin
      free_ext          = '1;
      free_ext[M-1:0]   = free;
   end

   assign x_ready = bcast ? (&free) : free_ext[addr];
   assign accept  = x_valid & x_ready;

   always_comb begin
      load = '0;
      for (int k = 0; k < M; k++) begin
         load[k] = accept & (bcast | (addr == AW'(k)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_valid <= '0;
         for (int k = 0; k < M; k++) begin
            hold[k] <= '0;
         end
      end else begin
         for (int k = 0; k < M; k++) begin
            if (load[k]) begin
               hold[k]    <= X;
               y_valid[k] <= 1'b1;
            end else if (y_ready[k]) begin
               y_valid[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (accept && !bcast && !in_range && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   // Output slices come only from registers, so there is no path from the
   // input side to Y; the idle value follows y_valid, which also makes reset
   // take effect on Y immediately.
   for (genvar k = 0; k < M; k++) begin : g_out
      if (IDLE_Z != 0) begin : g_z
         assign Y[k*N +: N] = y_valid[k] ? hold[k] : {N{1'bz}};
      end else begin : g_zero
         assign Y[k*N +: N] = y_valid[k] ? hold[k] : {N{1'b0}};
      end
   end

endmodule

// File: tb/tb_bus_dmx_1_m_reg.sv
// tb_bus_dmx_1_m_reg
// Bench for bus_dmx_1_m_reg. Main instance uses default parameters (M = 8,
// Z idle); a second instance (M = 6, zero idle) exercises out-of-range
// addresses. The reference model keeps one queue of pending words per
// channel: a word is pushed when accepted and popped when the sink takes it.

module tb_bus_dmx_1_m_reg;

   localparam int N  = 8;
   localparam int M  = 8;
   localparam int AW = 3;
   localparam int M6 = 6;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0]   addr    = '0;
   logic            bcast   = 1'b0;
   logic [N-1:0]    x       = '0;
   logic            x_valid = 1'b0;
   logic            x_ready;
   wire  [M*N-1:0]  y;
   logic [M-1:0]    y_valid;
   logic [M-1:0]    y_ready = '1;
   logic [CW-1:0]   err_cnt;

   logic [AW-1:0]   addr6    = '0;
   logic            bcast6   = 1'b0;
   logic [N-1:0]    x6       = '0;
   logic            x_valid6 = 1'b0;
   logic            x_ready6;
   wire  [M6*N-1:0] y6;
   logic [M6-1:0]   y_valid6;
   logic [M6-1:0]   y_ready6 = '1;
   logic [CW-1:0]   err6;

   bus_dmx_1_m_reg #(.N(N), .M(M), .AW(AW), .IDLE_Z(1), .CW(CW)) dut (
      .clk(clk), .rst(rst), .addr(addr), .bcast(bcast), .X(x),
      .x_valid(x_valid), .x_ready(x_ready), .Y(y), .y_valid(y_valid),
      .y_ready(y_ready), .err_cnt(err_cnt)
   );

   bus_dmx_1_m_reg #(.N(N), .M(M6), .AW(AW), .IDLE_Z(0), .CW(CW)) dut6 (
      .clk(clk), .rst(rst), .addr(addr6), .bcast(bcast6), .X(x6),
      .x_valid(x_valid6), .x_ready(x_ready6), .Y(y6), .y_valid(y_valid6),
      .y_ready(y_ready6), .err_cnt(err6)
   );

   int checks   = 0;
   int failures = 0;

   logic [N-1:0]   exp_q [M][$];
   int             m6_err;
   logic [M*N-1:0] all_z = {(M*N){1'bz}};

   // ---------------- reference model ----------------
   function automatic logic [M-1:0] exp_valid();
      logic [M-1:0] v;
      for (int k = 0; k < M; k++) v[k] = (exp_q[k].size() != 0);
      return v;
   endfunction

   function automatic logic [M*N-1:0] exp_y();
      logic [M*N-1:0] r;
      for (int k = 0; k < M; k++)
         r[k*N +: N] = (exp_q[k].size() != 0) ? exp_q[k][0] : 8'hzz;
      return r;
   endfunction

   function automatic logic ch_free(input int k);
      return (exp_q[k].size() == 0) || y_ready[k];
   endfunction

   function automatic logic model_ready();
      logic r;
      if (bcast) begin
         r = 1'b1;
         for (int k = 0; k < M; k++) if (!ch_free(k)) r = 1'b0;
      end else begin
         r = ch_free(int'(addr));
      end
      return r;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < M; k++) exp_q[k].delete();
      m6_err = 0;
   endtask

   // One clock: decide acceptance from the pre-edge state, then apply
   // sink pops followed by new pushes.
   task automatic advance();
      logic acc;
      logic acc6;
      acc  = x_valid && model_ready();
      acc6 = x_valid6 && (int'(addr6) >= M6);
      @(posedge clk);
      for (int k = 0; k < M; k++)
         if (y_ready[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
      if (acc)
         for (int k = 0; k < M; k++)
            if (bcast || int'(addr) == k) exp_q[k].push_back(x);
      if (acc6 && m6_err < 255) m6_err++;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_model();
      #1;
      checks++;
      if (y_valid !== '0) begin failures++; $display("FAIL reset_valid got=%b exp=0", y_valid); end
      checks++;
      if (y !== all_z) begin failures++; $display("FAIL reset_y got=%h exp=all-z", y); end
      checks++;
      if (err_cnt !== '0 || err6 !== '0) begin failures++; $display("FAIL reset_err got=%0d/%0d exp=0", err_cnt, err6); end
      checks++;
      if (y6 !== '0 || y_valid6 !== '0) begin failures++; $display("FAIL reset_dut6 y=%h v=%b exp=0", y6, y_valid6); end
      for (int a = 0; a < M; a++) begin
         @(negedge clk);
         addr = AW'(a);
         #1;
         checks++;
         if (x_ready !== 1'b1) begin failures++; $display("FAIL reset_ready addr=%0d got=%b exp=1", a, x_ready); end
      end
      bcast = 1'b1;
      #1;
      checks++;
      if (x_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_bcast got=%b exp=1", x_ready); end
      bcast = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unicast();
      y_ready = '1; addr = 3'd3; x = 8'hA5; x_valid = 1'b1;
      #1;
      checks++;
      if (x_ready !== 1'b1) begin failures++; $display("FAIL uni_ready got=%b exp=1", x_ready); end
      advance();
      x_valid = 1'b0;
      #1;
      checks++;
      if (y_valid !== 8'b0000_1000) begin failures++; $display("FAIL uni_valid got=%b exp=00001000", y_valid); end
      checks++;
      if (y[31:24] !== 8'hA5) begin failures++; $display("FAIL uni_data got=%h exp=a5", y[31:24]); end
      checks++;
      if (y !== exp_y()) begin failures++; $display("FAIL uni_y got=%h exp=%h", y, exp_y()); end
      checks++;
      if (err_cnt !== '0) begin failures++; $display("FAIL uni_err got=%0d exp=0", err_cnt); end
      advance();
      #1;
      checks++;
      if (y_valid !== '0) begin failures++; $display("FAIL uni_one_cycle got=%b exp=0", y_valid); end
   endtask

   task automatic test_backpressure();
      y_ready = 8'hFB; addr = 3'd2; x = 8'h11; x_valid = 1'b1;
      #1;
      checks++;
      if (x_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", x_ready); end
      advance();
      x = 8'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (x_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", x_ready); end
         checks++;
         if (y[23:16] !== 8'h11 || y_valid !== 8'b0000_0100) begin
            failures++; $display("FAIL bp_hold got=%h/%b exp=11/00000100", y[23:16], y_valid);
         end
         advance();
      end
      y_ready = '1;
      #1;
      checks++;
      if (x_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", x_ready); end
      advance();
      addr = 3'd5; x = 8'h33;
      #1;
      checks++;
      if (y[23:16] !== 8'h22 || y_valid !== 8'b0000_0100) begin
         failures++; $display("FAIL bp_second got=%h/%b exp=22/00000100", y[23:16], y_valid);
      end
      advance();
      x_valid = 1'b0;
      #1;
      checks++;
      if (y[47:40] !== 8'h33 || y_valid !== 8'b0010_0000) begin
         failures++; $display("FAIL bp_ch5 got=%h/%b exp=33/00100000", y[47:40], y_valid);
      end
      advance();
   endtask

   task automatic test_streaming();
      y_ready = '1; addr = 3'd6;
      for (int i = 1; i <= 16; i++) begin
         x = 8'(i); x_valid = 1'b1;
         #1;
         checks++;
         if (x_ready !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, x_ready); end
         if (i > 1) begin
            checks++;
            if (y[55:48] !== 8'(i-1) || y_valid !== 8'h40) begin
               failures++; $display("FAIL stream_out i=%0d got=%h/%b exp=%h/01000000", i, y[55:48], y_valid, 8'(i-1));
            end
         end
         advance();
      end
      x_valid = 1'b0;
      #1;
      checks++;
      if (y[55:48] !== 8'h10 || y_valid !== 8'h40) begin failures++; $display("FAIL stream_last got=%h/%b exp=10/01000000", y[55:48], y_valid); end
      advance();
      #1;
      checks++;
      if (y_valid !== '0) begin failures++; $display("FAIL stream_drain got=%b exp=0", y_valid); end
   endtask

   task automatic test_broadcast();
      y_ready = 8'hEF; addr = 3'd4; x = 8'h77; x_valid = 1'b1;
      advance();
      bcast = 1'b1; x = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (x_ready !== 1'b0 || y[39:32] !== 8'h77) begin
            failures++; $display("FAIL bc_stall got=%b/%h exp=0/77", x_ready, y[39:32]);
         end
         advance();
      end
      y_ready = '1;
      #1;
      checks++;
      if (x_ready !== 1'b1) begin failures++; $display("FAIL bc_ready got=%b exp=1", x_ready); end
      advance();
      bcast = 1'b0; x_valid = 1'b0;
      #1;
      checks++;
      if (y_valid !== 8'hFF) begin failures++; $display("FAIL bc_valid got=%b exp=11111111", y_valid); end
      for (int k = 0; k < M; k++) begin
         checks++;
         if (y[k*N +: N] !== 8'h5A) begin failures++; $display("FAIL bc_data ch=%0d got=%h exp=5a", k, y[k*N +: N]); end
      end
      advance();
      #1;
      checks++;
      if (y_valid !== '0) begin failures++; $display("FAIL bc_drain got=%b exp=0", y_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         x_valid = 1'($urandom_range(0, 1));
         bcast   = ($urandom_range(0, 7) == 0);
         addr    = AW'($urandom_range(0, M-1));
         x       = 8'($urandom_range(0, 255));
         y_ready = 8'($urandom_range(0, 255));
         #1;
         checks++;
         if (x_ready !== model_ready()) begin failures++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, x_ready, model_ready()); end
         checks++;
         if (y_valid !== exp_valid()) begin failures++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, y_valid, exp_valid()); end
         checks++;
         if (y !== exp_y()) begin failures++; $display("FAIL rnd_y i=%0d got=%h exp=%h", i, y, exp_y()); end
         advance();
      end
      x_valid = 1'b0; bcast = 1'b0; y_ready = '1;
      advance();
      #1;
      checks++;
      if (y_valid !== '0) begin failures++; $display("FAIL rnd_drain got=%b exp=0", y_valid); end
   endtask

   task automatic test_out_of_range();
      for (int i = 0; i < 300; i++) begin
         addr6    = AW'($urandom_range(M6, (1 << AW) - 1));
         x6       = 8'($urandom_range(0, 255));
         x_valid6 = 1'b1;
         #1;
         checks++;
         if (x_ready6 !== 1'b1) begin failures++; $display("FAIL oor_ready i=%0d got=%b exp=1", i, x_ready6); end
         advance();
         checks++;
         if (y_valid6 !== '0 || y6 !== '0) begin failures++; $display("FAIL oor_out i=%0d got=%b/%h exp=0/0", i, y_valid6, y6); end
         checks++;
         if (int'(err6) != m6_err) begin failures++; $display("FAIL oor_err i=%0d got=%0d exp=%0d", i, err6, m6_err); end
      end
      x_valid6 = 1'b0;
      advance();
      checks++;
      if (err6 !== 8'd255) begin failures++; $display("FAIL oor_sat got=%0d exp=255", err6); end
   endtask

   task automatic test_reset_mid();
      y_ready = '0; bcast = 1'b0; x_valid = 1'b1;
      addr = 3'd0; x = 8'hC0; advance();
      addr = 3'd1; x = 8'hC1; advance();
      addr = 3'd7; x = 8'hC7; advance();
      x_valid = 1'b0;
      #1;
      checks++;
      if (y_valid !== 8'b1000_0011) begin failures++; $display("FAIL mid_fill got=%b exp=10000011", y_valid); end
      #1;
      rst = 1'b1;
      #1;
      clear_model();
      checks++;
      if (y_valid !== '0) begin failures++; $display("FAIL mid_valid got=%b exp=0", y_valid); end
      checks++;
      if (y !== all_z) begin failures++; $display("FAIL mid_y got=%h exp=all-z", y); end
      repeat (2) @(negedge clk);
      rst = 1'b0; y_ready = '1;
      advance();
      #1;
      checks++;
      if (y_valid !== '0 || y !== all_z) begin failures++; $display("FAIL mid_stale got=%b/%h exp=0/all-z", y_valid, y); end
   endtask

   initial begin
      clear_model();
      test_reset();
      test_unicast();
      test_backpressure();
      test_streaming();
      test_broadcast();
      test_random();
      test_out_of_range();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
